// File: rtl/seq_lib_pkg.sv
// Shared constants for the sequential-circuits library.
// Holds the JK command encodings and the counter direction codes.
package seq_lib_pkg;
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    localparam logic DIR_DN = 1'b0;
    localparam logic DIR_UP = 1'b1;
endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-high reset.
// It is the only storage element of the counter bank.
module jk_cell
    import seq_lib_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                JK_HOLD: q <= q;
                JK_RST:  q <= 1'b0;
                JK_SET:  q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

endmodule

// File: rtl/jk_sync_counter.sv
// Up/down counter with modulus, wrap/saturate, load and raw JK modes.
// Every bit of q lives in a jk_cell; this module only forms the J/K drive.
module jk_sync_counter
    import seq_lib_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             raw,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] n_p0;
    logic [WIDTH-1:0] jc_p0;
    logic [WIDTH-1:0] kc_p0;
    logic             raw_sel_p0;
    logic             wrap_p0;

    // Stage p0: target value and J/K drive, priority load > raw > count > hold
    always_comb begin
        n_p0    = q;
        wrap_p0 = 1'b0;
        if (load) begin
            n_p0 = (load_val > MAXV) ? MAXV : load_val;
        end else if (raw) begin
            n_p0 = q;
        end else if (en) begin
            if (up == DIR_UP) begin
                if (q < MAXV) begin
                    n_p0 = q + 1'b1;
                end else if (!SATURATE) begin
                    n_p0    = '0;
                    wrap_p0 = 1'b1;
                end
            end else begin
                // Out-of-range values fold back to the terminal count without a wrap
                if (q > MAXV) begin
                    n_p0 = MAXV;
                end else if (q != '0) begin
                    n_p0 = q - 1'b1;
                end else if (!SATURATE) begin
                    n_p0    = MAXV;
                    wrap_p0 = 1'b1;
                end
            end
        end
    end

    assign raw_sel_p0 = raw && !load;
    assign jc_p0      = raw_sel_p0 ? j : (n_p0 & ~q);
    assign kc_p0      = raw_sel_p0 ? k : (~n_p0 & q);

    // Stage p1: flop bank and wrap pulse register
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (jc_p0[i]),
            .k   (kc_p0[i]),
            .q   (q[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_p0;
        end
    end

    assign tc = (up == DIR_UP) ? (q == MAXV) : (q == '0);

endmodule

// File: tb/tb_jk_sync_counter.sv
// Scoreboard bench for jk_sync_counter, modulus 10, wrap and saturate builds side by side.
module tb_jk_sync_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, up = 1'b1, load = 1'b0, raw = 1'b0;
    logic [3:0] load_val = '0, j = '0, k = '0;
    logic [3:0] qw, qs;
    logic       tcw, tcs, wrw, wrs;

    typedef struct packed {
        logic [3:0] qw; logic ww; logic tw;
        logic [3:0] qs; logic ws; logic ts;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    rec_t e_, o_;
    int compared = 0;
    int mism = 0;

    always #5 clk = ~clk;

    jk_sync_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .raw(raw), .j(j), .k(k), .q(qw), .tc(tcw), .wrap(wrw));

    jk_sync_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .raw(raw), .j(j), .k(k), .q(qs), .tc(tcs), .wrap(wrs));

    // Drive one cycle, queue the expected state, capture the observed state after the edge
    task automatic cyc(input logic ld, input logic [3:0] lv, input logic rw,
                       input logic [3:0] jj, input logic [3:0] kk, input logic e, input logic u,
                       input logic [3:0] eqw, input logic eww, input logic [3:0] eqs, input logic ews);
        load = ld; load_val = lv; raw = rw; j = jj; k = kk; en = e; up = u;
        exp_q.push_back('{qw: eqw, ww: eww, tw: (u ? (eqw == 4'd9) : (eqw == 4'd0)),
                          qs: eqs, ws: ews, ts: (u ? (eqs == 4'd9) : (eqs == 4'd0))});
        @(posedge clk);
        #1;
        obs_q.push_back('{qw: qw, ww: wrw, tw: tcw, qs: qs, ws: wrs, ts: tcs});
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ({qw, wrw, qs, wrs} !== 10'b0) begin
            mism++;
            $display("FAIL reset_hold: got qw=%0d wrap=%b qs=%0d wrap=%b, want 0/0 0/0", qw, wrw, qs, wrs);
        end
        rst = 1'b0;
        cyc(1, 4'd6, 0, 0, 0, 0, 1, 4'd6, 0, 4'd6, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 4'd7, 0, 4'd7, 0);
        #2 rst = 1'b1;
        #1;
        compared++;
        if ({qw, wrw, qs, wrs} !== 10'b0) begin
            mism++;
            $display("FAIL reset_async: got qw=%0d wrap=%b qs=%0d wrap=%b, want 0/0 0/0", qw, wrw, qs, wrs);
        end
        #1 rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 1, 1, 4'd1, 0, 4'd1, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 4'd2, 0, 4'd2, 0);
        cyc(1, 4'd9, 0, 0, 0, 0, 1, 4'd9, 0, 4'd9, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 4'd0, 1, 4'd9, 0);
        #2 rst = 1'b1;
        #1;
        compared++;
        if ({qw, wrw, qs, wrs} !== 10'b0) begin
            mism++;
            $display("FAIL reset_wrap: got qw=%0d wrap=%b qs=%0d wrap=%b, want 0/0 0/0", qw, wrw, qs, wrs);
        end
        #1 rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 1, 4'd0, 0, 4'd0, 0);
        while (exp_q.size() != 0) begin
            e_ = exp_q.pop_front(); o_ = obs_q.pop_front(); compared++;
            if (o_ !== e_) begin
                mism++;
                $display("FAIL reset_seq: got qw=%0d w=%b tc=%b qs=%0d w=%b tc=%b, want qw=%0d w=%b tc=%b qs=%0d w=%b tc=%b",
                         o_.qw, o_.ww, o_.tw, o_.qs, o_.ws, o_.ts, e_.qw, e_.ww, e_.tw, e_.qs, e_.ws, e_.ts);
            end
        end
    endtask

    task automatic test_count_up;
        cyc(1, 4'd0, 0, 0, 0, 0, 1, 4'd0, 0, 4'd0, 0);
        for (int i = 1; i <= 11; i++)
            cyc(0, 0, 0, 0, 0, 1, 1, 4'(i % 10), (i == 10), 4'((i > 9) ? 9 : i), 0);
        while (exp_q.size() != 0) begin
            e_ = exp_q.pop_front(); o_ = obs_q.pop_front(); compared++;
            if (o_ !== e_) begin
                mism++;
                $display("FAIL count_up: got qw=%0d w=%b tc=%b qs=%0d w=%b tc=%b, want qw=%0d w=%b tc=%b qs=%0d w=%b tc=%b",
                         o_.qw, o_.ww, o_.tw, o_.qs, o_.ws, o_.ts, e_.qw, e_.ww, e_.tw, e_.qs, e_.ws, e_.ts);
            end
        end
    endtask

    task automatic test_count_down;
        cyc(1, 4'd1, 0, 0, 0, 0, 0, 4'd1, 0, 4'd1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 4'd0, 0, 4'd0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 4'd9, 1, 4'd0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 4'd8, 0, 4'd0, 0);
        while (exp_q.size() != 0) begin
            e_ = exp_q.pop_front(); o_ = obs_q.pop_front(); compared++;
            if (o_ !== e_) begin
                mism++;
                $display("FAIL count_down: got qw=%0d w=%b tc=%b qs=%0d w=%b tc=%b, want qw=%0d w=%b tc=%b qs=%0d w=%b tc=%b",
                         o_.qw, o_.ww, o_.tw, o_.qs, o_.ws, o_.ts, e_.qw, e_.ww, e_.tw, e_.qs, e_.ws, e_.ts);
            end
        end
    endtask

    task automatic test_load;
        cyc(1, 4'd12, 0, 0, 0, 0, 1, 4'd9, 0, 4'd9, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 4'd0, 1, 4'd9, 0);
        cyc(1, 4'd2, 0, 0, 0, 1, 1, 4'd2, 0, 4'd2, 0);
        cyc(1, 4'd3, 1, 4'hF, 4'h0, 1, 1, 4'd3, 0, 4'd3, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 4'd3, 0, 4'd3, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 4'd3, 0, 4'd3, 0);
        while (exp_q.size() != 0) begin
            e_ = exp_q.pop_front(); o_ = obs_q.pop_front(); compared++;
            if (o_ !== e_) begin
                mism++;
                $display("FAIL load: got qw=%0d w=%b tc=%b qs=%0d w=%b tc=%b, want qw=%0d w=%b tc=%b qs=%0d w=%b tc=%b",
                         o_.qw, o_.ww, o_.tw, o_.qs, o_.ws, o_.ts, e_.qw, e_.ww, e_.tw, e_.qs, e_.ws, e_.ts);
            end
        end
    endtask

    task automatic test_raw;
        cyc(1, 4'd0, 0, 0, 0, 0, 1, 4'd0, 0, 4'd0, 0);
        cyc(0, 0, 1, 4'b1010, 4'b0000, 1, 1, 4'b1010, 0, 4'b1010, 0);
        cyc(0, 0, 1, 4'b0101, 4'b1001, 1, 1, 4'b0111, 0, 4'b0111, 0);
        cyc(0, 0, 1, 4'b1111, 4'b1111, 1, 1, 4'b1000, 0, 4'b1000, 0);
        cyc(0, 0, 1, 4'b0000, 4'b0000, 1, 1, 4'b1000, 0, 4'b1000, 0);
        while (exp_q.size() != 0) begin
            e_ = exp_q.pop_front(); o_ = obs_q.pop_front(); compared++;
            if (o_ !== e_) begin
                mism++;
                $display("FAIL raw: got qw=%0d w=%b tc=%b qs=%0d w=%b tc=%b, want qw=%0d w=%b tc=%b qs=%0d w=%b tc=%b",
                         o_.qw, o_.ww, o_.tw, o_.qs, o_.ws, o_.ts, e_.qw, e_.ww, e_.tw, e_.qs, e_.ws, e_.ts);
            end
        end
    endtask

    task automatic test_out_of_range;
        cyc(1, 4'd0, 0, 0, 0, 0, 1, 4'd0, 0, 4'd0, 0);
        cyc(0, 0, 1, 4'b1110, 4'b0000, 0, 1, 4'd14, 0, 4'd14, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 4'd0, 1, 4'd14, 0);
        cyc(0, 0, 1, 4'b1110, 4'b0001, 0, 1, 4'd14, 0, 4'd14, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 4'd9, 0, 4'd9, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 4'd8, 0, 4'd8, 0);
        while (exp_q.size() != 0) begin
            e_ = exp_q.pop_front(); o_ = obs_q.pop_front(); compared++;
            if (o_ !== e_) begin
                mism++;
                $display("FAIL out_of_range: got qw=%0d w=%b tc=%b qs=%0d w=%b tc=%b, want qw=%0d w=%b tc=%b qs=%0d w=%b tc=%b",
                         o_.qw, o_.ww, o_.tw, o_.qs, o_.ws, o_.ts, e_.qw, e_.ww, e_.tw, e_.qs, e_.ws, e_.ts);
            end
        end
    endtask

    initial begin
        test_reset;
        test_count_up;
        test_count_down;
        test_load;
        test_raw;
        test_out_of_range;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
